loop_uhat_sparse_sdiv_54s_6ns_54_seq: RTL and testbench

Iterative radix-2 signed-by-unsigned divider. It is the inverse operator of the sparse loop's pipelined 54s×6ns multiplier: it recovers a quotient and remainder from a signed 54-bit dividend and an unsigned 6-bit divisor. It sits in the loop_uhat_sparse datapath and is driven by the HLS-style FSM through a start/ready/done handshake and the global ce. It computes one quotient bit per cycle, with C semantics: truncate toward zero, remainder takes the dividend's sign.

---
 rtl/loop_uhat_sparse_sdiv_54s_6ns_54_seq.sv | 143 ++++++++++++++
 tb/tb_loop_uhat_sparse_sdiv_54s_6ns_54_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/loop_uhat_sparse_sdiv_54s_6ns_54_seq.sv
// Iterative radix-2 restoring divider for the loop_uhat_sparse datapath.
// It takes a signed dividend and an unsigned divisor, and produces one quotient bit per enabled cycle.
// Results follow C semantics: the quotient truncates toward zero and the remainder takes the dividend's sign.
module loop_uhat_sparse_sdiv_54s_6ns_54_seq #(
    parameter int ID         = 1,
    parameter int DIN0_WIDTH = 54,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 54
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [DOUT_WIDTH-1:0] quot,
    output logic [DIN1_WIDTH:0]   rem,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIN0_WIDTH);

    // The quotient shares the dividend shift register, so both must be the same width.
    // The instance tag is only a label, but a negative value points to a broken instantiation.
    if (DOUT_WIDTH != DIN0_WIDTH || ID < 0) begin : g_bad_params
        $error("loop_uhat_sparse_sdiv: DOUT_WIDTH must equal DIN0_WIDTH and ID must be non-negative");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic [DIN0_WIDTH-1:0] dvd;
    logic [DIN1_WIDTH:0]   part_rem;
    logic [DIN1_WIDTH-1:0] divisor;
    logic                  sign;
    logic                  dz;

    logic [DIN0_WIDTH-1:0] din0_mag;
    logic [DIN1_WIDTH:0]   partial;
    logic [DIN1_WIDTH:0]   diff;
    logic                  ge;
    logic                  last_step;
    logic [DOUT_WIDTH-1:0] fix_quot;
    logic [DIN1_WIDTH:0]   fix_rem;

    // Ready is purely a function of being idle, so it rises in the same cycle as done.
    assign ready = (state == S_IDLE);

    // The magnitude of the most negative dividend, 2^(W-1), still fits in W unsigned bits.
    // Each step shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
    // The partial remainder is always below the divisor, so its top bit is free to receive the shifted-in bit.
    always_comb begin
        din0_mag  = din0[DIN0_WIDTH-1] ? -din0 : din0;
        partial   = {part_rem[DIN1_WIDTH-1:0], dvd[DIN0_WIDTH-1]};
        diff      = partial - {1'b0, divisor};
        ge        = (partial >= {1'b0, divisor});
        last_step = (cnt == CNT_W'(DIN0_WIDTH - 1));
    end

    // Signs are restored on the unsigned quotient and remainder.
    // A zero divisor overrides them with all-ones and zero, respectively.
    always_comb begin
        fix_quot = sign ? -dvd : dvd;
        fix_rem  = sign ? -part_rem : part_rem;
        if (dz) begin
            fix_quot = '1;
            fix_rem  = '0;
        end
    end

    // Next-state logic: accept in idle, run DIN0_WIDTH steps, then spend one cycle fixing signs.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_BUSY;
            S_BUSY:  if (last_step) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register, which advances only on enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (ce) begin
            state <= next_state;
        end
    end

    // Operand capture, restoring steps and result registration, all frozen while ce is low.
    // Done is rewritten only on enabled cycles, so a pulse stretches across ce-low cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            dvd         <= '0;
            part_rem    <= '0;
            divisor     <= '0;
            sign        <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (ce) begin
            done <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd      <= din0_mag;
                        sign     <= din0[DIN0_WIDTH-1];
                        divisor  <= din1;
                        dz       <= (din1 == '0);
                        part_rem <= '0;
                        cnt      <= '0;
                    end
                end
                S_BUSY: begin
                    dvd      <= {dvd[DIN0_WIDTH-2:0], ge};
                    part_rem <= ge ? diff : partial;
                    cnt      <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    quot        <= fix_quot;
                    rem         <= fix_rem;
                    div_by_zero <= dz;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_uhat_sparse_sdiv_54s_6ns_54_seq.sv
// Directed bench for the 54s/6ns sequential divider.
// Expected quotients, remainders and latencies are hand-computed constants.
module tb_loop_uhat_sparse_sdiv_54s_6ns_54_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [53:0] din0;
    logic [5:0]  din1;
    logic        ready;
    logic        done;
    logic [53:0] quot;
    logic [6:0]  rem;
    logic        div_by_zero;

    int tests_run;
    int tests_failed;
    int n;
    int seen_done;

    loop_uhat_sparse_sdiv_54s_6ns_54_seq #(
        .ID(1),
        .DIN0_WIDTH(54),
        .DIN1_WIDTH(6),
        .DOUT_WIDTH(54)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .start(start),
        .din0(din0),
        .din1(din1),
        .ready(ready),
        .done(done),
        .quot(quot),
        .rem(rem),
        .div_by_zero(div_by_zero)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with a single-cycle start pulse.
    // The task returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [53:0] a, input logic [5:0] b);
        @(negedge clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done rises, bounded so that a missing done fails the latency check.
    task automatic waitDone(inout int cycles);
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Check every result of one division, including its latency.
    task automatic checkResult(input string tag, input int cycles, input int exp_cycles,
                               input logic [53:0] exp_q, input logic [6:0] exp_r, input logic exp_dz);
        checkOutput({tag, " latency"}, 64'(cycles), 64'(exp_cycles));
        checkOutput({tag, " quot"}, 64'(quot), 64'(exp_q));
        checkOutput({tag, " rem"}, 64'(rem), 64'(exp_r));
        checkOutput({tag, " dz"}, 64'(div_by_zero), 64'(exp_dz));
        checkOutput({tag, " ready"}, 64'(ready), 64'(1'b1));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;

        // While reset is held, the block is idle and every result is cleared.
        #3;
        checkOutput("reset ready", 64'(ready), 64'(1'b1));
        checkOutput("reset done", 64'(done), 64'(1'b0));
        checkOutput("reset quot", 64'(quot), 64'(0));
        checkOutput("reset rem", 64'(rem), 64'(0));
        checkOutput("reset dz", 64'(div_by_zero), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        // 100 / 7 = 14 r 2. Done must last exactly one cycle.
        applyStimulus(54'd100, 6'd7);
        n = 0; waitDone(n);
        checkResult("100/7", n, 55, 54'd14, 7'd2, 1'b0);
        @(negedge clk);
        checkOutput("100/7 done pulse", 64'(done), 64'(1'b0));

        // -100 / 7 = -14 r -2.
        applyStimulus(54'h3FFFFFFFFFFF9C, 6'd7);
        n = 0; waitDone(n);
        checkResult("-100/7", n, 55, 54'h3FFFFFFFFFFFF2, 7'h7E, 1'b0);

        // 100 / 63 = 1 r 37.
        applyStimulus(54'd100, 6'd63);
        n = 0; waitDone(n);
        checkResult("100/63", n, 55, 54'd1, 7'd37, 1'b0);

        // -1 / 2 = 0 r -1.
        applyStimulus(54'h3FFFFFFFFFFFFF, 6'd2);
        n = 0; waitDone(n);
        checkResult("-1/2", n, 55, 54'd0, 7'h7F, 1'b0);

        // -2^53 / 1 = -2^53 r 0.
        applyStimulus(54'h20000000000000, 6'd1);
        n = 0; waitDone(n);
        checkResult("-2^53/1", n, 55, 54'h20000000000000, 7'd0, 1'b0);

        // (2^53-1) / 63 = 142971416741920 r 31.
        applyStimulus(54'h1FFFFFFFFFFFFF, 6'd63);
        n = 0; waitDone(n);
        checkResult("maxpos/63", n, 55, 54'd142971416741920, 7'd31, 1'b0);

        // A zero divisor takes the full latency, then flags the error with an all-ones quotient.
        applyStimulus(54'd12345, 6'd0);
        n = 0; waitDone(n);
        checkResult("12345/0", n, 55, 54'h3FFFFFFFFFFFFF, 7'd0, 1'b1);

        // The next valid division clears the flag.
        applyStimulus(54'd100, 6'd7);
        n = 0; waitDone(n);
        checkResult("after dz", n, 55, 54'd14, 7'd2, 1'b0);

        // Start held high with changing operands while busy; only 1000 / 9 = 111 r 1 counts.
        applyStimulus(54'd1000, 6'd9);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            din0  = 54'({$urandom(), $urandom()});
            din1  = 6'($urandom());
            start = 1'b1;
            @(negedge clk);
            n++;
        end
        checkResult("busy start", n, 55, 54'd111, 7'd1, 1'b0);

        // A start in the done cycle is accepted back-to-back: 100 / 63 = 1 r 37.
        din0  = 54'd100;
        din1  = 6'd63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b ready low", 64'(ready), 64'(1'b0));
        n = 0; waitDone(n);
        checkResult("b2b", n, 55, 54'd1, 7'd37, 1'b0);

        // ce is low for 10 cycles mid-division, which stretches latency to 65: 500 / 7 = 71 r 3.
        applyStimulus(54'd500, 6'd7);
        n = 0;
        repeat (20) begin @(negedge clk); n++; end
        ce    = 1'b0;
        start = 1'b1;
        din0  = 54'd9;
        din1  = 6'd3;
        repeat (10) begin @(negedge clk); n++; end
        ce    = 1'b1;
        start = 1'b0;
        waitDone(n);
        checkResult("ce freeze", n, 65, 54'd71, 7'd3, 1'b0);

        // Done holds through ce-low cycles, and start is ignored meanwhile.
        ce    = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("ce hold done", 64'(done), 64'(1'b1));
        checkOutput("ce hold quot", 64'(quot), 64'(54'd71));
        start = 1'b0;
        ce    = 1'b1;
        @(negedge clk);
        checkOutput("ce release done", 64'(done), 64'(1'b0));
        checkOutput("ce start ignored", 64'(ready), 64'(1'b1));

        // Reset 20 cycles into a division clears everything immediately, and no done follows.
        applyStimulus(54'd100, 6'd7);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort ready", 64'(ready), 64'(1'b1));
        checkOutput("abort done", 64'(done), 64'(1'b0));
        checkOutput("abort quot", 64'(quot), 64'(0));
        checkOutput("abort rem", 64'(rem), 64'(0));
        checkOutput("abort dz", 64'(div_by_zero), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
        end
        checkOutput("abort no done", 64'(seen_done), 64'(0));

        // A fresh division after reset completes normally: 200 / 6 = 33 r 2.
        applyStimulus(54'd200, 6'd6);
        n = 0; waitDone(n);
        checkResult("after abort", n, 55, 54'd33, 7'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
